mux8way16: RTL and testbench



---
 rtl/gates_pkg.sv | 14 +
 rtl/mux.sv | 18 +
 rtl/mux16.sv | 27 ++
 rtl/mux4way16.sv | 45 ++++
 rtl/mux8way16.sv | 69 ++++++
 tb/tb_mux8way16.sv | 184 ++++++++++++++++++
 6 files changed

// File: rtl/gates_pkg.sv
// ============================================================================
// gates_pkg : shared widths and word type for the combinational gate library
// Rev 1.0
// ============================================================================
`default_nettype none

package gates_pkg;
  localparam int WORD_W = 16;
  localparam int SEL8_W = 3;

  typedef logic [WORD_W-1:0] word_t;
endpackage : gates_pkg

`default_nettype wire

// File: rtl/mux.sv
// ============================================================================
// mux : 1-bit two-way selector (sel_i=0 -> a_i, sel_i=1 -> b_i)
// Rev 1.0
// ============================================================================
`default_nettype none

module mux (
  input  logic a_i,
  input  logic b_i,
  input  logic sel_i,
  output logic out_o
);

  assign out_o = sel_i ? b_i : a_i;

endmodule : mux

`default_nettype wire

// File: rtl/mux16.sv
// ============================================================================
// mux16 : 16-bit two-way selector built from sixteen independent 1-bit muxes
// Rev 1.0
// ============================================================================
`default_nettype none

module mux16
  import gates_pkg::*;
(
  input  word_t a_i,
  input  word_t b_i,
  input  logic  sel_i,
  output word_t out_o
);

  for (genvar i = 0; i < WORD_W; i++) begin : g_bit
    mux u_mux (
      .a_i   (a_i[i]),
      .b_i   (b_i[i]),
      .sel_i (sel_i),
      .out_o (out_o[i])
    );
  end

endmodule : mux16

`default_nettype wire

// File: rtl/mux4way16.sv
// ============================================================================
// mux4way16 : 16-bit four-way selector (00->a, 01->b, 10->c, 11->d)
// Rev 1.0
// ============================================================================
`default_nettype none

module mux4way16
  import gates_pkg::*;
(
  input  word_t       a_i,
  input  word_t       b_i,
  input  word_t       c_i,
  input  word_t       d_i,
  input  logic  [1:0] sel_i,
  output word_t       out_o
);

  word_t w_ab;
  word_t w_cd;

  // sel_i[0] picks within each pair, sel_i[1] picks the pair
  mux16 u_mux_ab (
    .a_i   (a_i),
    .b_i   (b_i),
    .sel_i (sel_i[0]),
    .out_o (w_ab)
  );

  mux16 u_mux_cd (
    .a_i   (c_i),
    .b_i   (d_i),
    .sel_i (sel_i[0]),
    .out_o (w_cd)
  );

  mux16 u_mux_out (
    .a_i   (w_ab),
    .b_i   (w_cd),
    .sel_i (sel_i[1]),
    .out_o (out_o)
  );

endmodule : mux4way16

`default_nettype wire

// File: rtl/mux8way16.sv
// ============================================================================
// mux8way16 : 16-bit eight-way selector with combinational and registered out
// Rev 1.0
// ============================================================================
`default_nettype none

module mux8way16
  import gates_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [WIDTH-1:0]  c,
  input  logic [WIDTH-1:0]  d,
  input  logic [WIDTH-1:0]  e,
  input  logic [WIDTH-1:0]  f,
  input  logic [WIDTH-1:0]  g,
  input  logic [WIDTH-1:0]  h,
  input  logic [SEL8_W-1:0] sel,
  output logic [WIDTH-1:0]  out,
  output logic [WIDTH-1:0]  out_q
);

  word_t w_lo;
  word_t w_hi;
  word_t out_d;

  mux4way16 u_mux_lo (
    .a_i   (a),
    .b_i   (b),
    .c_i   (c),
    .d_i   (d),
    .sel_i (sel[1:0]),
    .out_o (w_lo)
  );

  mux4way16 u_mux_hi (
    .a_i   (e),
    .b_i   (f),
    .c_i   (g),
    .d_i   (h),
    .sel_i (sel[1:0]),
    .out_o (w_hi)
  );

  mux16 u_mux_grp (
    .a_i   (w_lo),
    .b_i   (w_hi),
    .sel_i (sel[2]),
    .out_o (out_d)
  );

  assign out = out_d;

  // Reset only touches the registered copy; the combinational path stays live
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

endmodule : mux8way16

`default_nettype wire

// File: tb/tb_mux8way16.sv
// ============================================================================
// tb_mux8way16 : self-checking bench for mux8way16 (vector table + scoreboard)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux8way16;
  import gates_pkg::*;

  typedef struct packed {
    logic [2:0]       sel;
    logic [7:0][15:0] ins;
    logic [15:0]      exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] a, b, c, d, e, f, g, h;
  logic [2:0]  sel;
  logic [15:0] out;
  logic [15:0] out_q;

  int total = 0;
  int bad   = 0;

  word_t exp_q[$];

  logic [7:0][15:0] V;
  logic [7:0][15:0] Z;
  vec_t             tbl [24];

  mux8way16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .f     (f),
    .g     (g),
    .h     (h),
    .sel   (sel),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drive(input logic [7:0][15:0] ins, input logic [2:0] s);
    a = ins[0]; b = ins[1]; c = ins[2]; d = ins[3];
    e = ins[4]; f = ins[5]; g = ins[6]; h = ins[7];
    sel = s;
  endtask

  // Expected word enters the scoreboard with the stimulus, leaves 1 unit later
  task automatic apply(input string name, input logic [7:0][15:0] ins,
                       input logic [2:0] s, input logic [15:0] req);
    drive(ins, s);
    exp_q.push_back(req);
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      chk(name, out, exp_q.pop_front());
    end
  endtask

  initial begin
    logic [7:0][15:0] w;
    logic [15:0]      sw;

    V = {16'h89AB, 16'h789A, 16'h6789, 16'h5678,
         16'h4567, 16'h3456, 16'h2345, 16'h1234};
    Z = '0;
    for (int i = 0; i < 8; i++) tbl[i] = '{sel: 3'(i), ins: Z, exp: 16'h0000};
    tbl[8]  = '{sel: 3'd0, ins: V, exp: 16'h1234};
    tbl[9]  = '{sel: 3'd1, ins: V, exp: 16'h2345};
    tbl[10] = '{sel: 3'd2, ins: V, exp: 16'h3456};
    tbl[11] = '{sel: 3'd3, ins: V, exp: 16'h4567};
    tbl[12] = '{sel: 3'd4, ins: V, exp: 16'h5678};
    tbl[13] = '{sel: 3'd5, ins: V, exp: 16'h6789};
    tbl[14] = '{sel: 3'd6, ins: V, exp: 16'h789A};
    tbl[15] = '{sel: 3'd7, ins: V, exp: 16'h89AB};
    for (int i = 16; i < 24; i++)
      tbl[i] = (i % 2 == 0) ? '{sel: 3'd0, ins: V, exp: 16'h1234}
                            : '{sel: 3'd7, ins: V, exp: 16'h89AB};

    rst_n = 1'b0;
    drive(V, 3'd7);
    #1;
    chk("reset_out_q", out_q, 16'h0000);
    chk("out_in_reset", out, 16'h89AB);

    for (int i = 0; i < 24; i++) begin
      $sformat(sw, "");
      apply($sformatf("table[%0d]", i), tbl[i].ins, tbl[i].sel, tbl[i].exp);
    end

    // Only the selected port may influence out
    w = V;
    apply("hold_d", w, 3'd3, 16'h4567);
    w[3] = 16'hFFFF;
    apply("d_change", w, 3'd3, 16'hFFFF);
    for (int p = 0; p < 8; p++) begin
      if (p != 3) begin
        w = V; w[3] = 16'hFFFF; w[p] = ~V[p];
        apply($sformatf("unsel_port%0d", p), w, 3'd3, 16'hFFFF);
      end
    end

    // One-hot bit routing on every port
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < 16; k++) begin
        w = V;
        sw = 16'h0001 << k;
        w[p] = sw;
        apply($sformatf("onehot_p%0d_b%0d", p, k), w, 3'(p), sw);
      end
    end

    // Leave reset, capture on first edge
    @(negedge clk);
    drive(V, 3'd7);
    rst_n = 1'b1;
    #1;
    chk("no_capture_before_edge", out_q, 16'h0000);
    @(posedge clk); #1;
    chk("first_edge_capture", out_q, 16'h89AB);

    // Asynchronous assertion mid-run
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear", out_q, 16'h0000);
    chk("out_during_reset", out, 16'h89AB);
    @(posedge clk); #1;
    chk("held_in_reset", out_q, 16'h0000);
    chk("out_held_reset", out, 16'h89AB);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_edge", out_q, 16'h89AB);

    // Registered copy lags out by one cycle
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      drive(V, 3'(s));
      exp_q.push_back(V[s]);
      #1;
      chk($sformatf("lag_before_s%0d", s), out_q, (s == 0) ? 16'h89AB : V[s-1]);
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL lag_after_s%0d: scoreboard empty", s);
      end else begin
        chk($sformatf("lag_after_s%0d", s), out_q, exp_q.pop_front());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mux8way16

`default_nettype wire
